// File: rtl/i2c_pkg.sv
// Shared I2C definitions: arbiter state encoding and transaction field widths.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_PKT_W  = 5;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_START = 2'd1,
      ARB_BUSY  = 2'd2,
      ARB_GAP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping around.
module rr_pick
   import i2c_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int j;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any && req[j]) begin
            onehot[j] = 1'b1;
            idx       = IDX_W'(j);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters, one whole transaction at a time.
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 100,
   parameter int START_TMO  = 15
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            clk_en,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [I2C_ADDR_W*NUM_REQ-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]              req_rw,
   input  logic [I2C_PKT_W*NUM_REQ-1:0]    req_packets,
   input  logic [I2C_DATA_W*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              grant,
   output logic [NUM_REQ-1:0]              done,
   output logic [NUM_REQ-1:0]              err,
   output logic [NUM_REQ-1:0]              data_req,
   output logic [NUM_REQ-1:0]              data_ready,
   output logic [I2C_DATA_W-1:0]           rdata,
   output logic                            m_start,
   output logic [I2C_ADDR_W-1:0]           m_addr,
   output logic                            m_rw,
   output logic [I2C_PKT_W-1:0]            m_packets,
   output logic [I2C_DATA_W-1:0]           m_data,
   input  logic                            m_ready,
   input  logic                            m_data_req,
   input  logic                            m_data_ready,
   input  logic [I2C_DATA_W-1:0]           m_data_out
);

   localparam int         IDX_W    = $clog2(NUM_REQ);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] TMO_LAST = 8'(START_TMO - 1);

   arb_state_t         state;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   rr_ptr;
   logic [7:0]         tmo;
   logic [7:0]         gap_cnt;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
      if (int'(i) >= NUM_REQ - 1) return '0;
      return IDX_W'(int'(i) + 1);
   endfunction

   // done/err are cleared on every tick so they last exactly one clk_en period
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ARB_IDLE;
         grant   <= '0;
         owner   <= '0;
         rr_ptr  <= '0;
         tmo     <= '0;
         gap_cnt <= '0;
         m_start <= 1'b0;
         done    <= '0;
         err     <= '0;
      end else if (clk_en) begin
         done <= '0;
         err  <= '0;
         case (state)
            ARB_IDLE: begin
               if (m_ready && pick_any) begin
                  grant   <= pick_onehot;
                  owner   <= pick_idx;
                  m_start <= 1'b1;
                  tmo     <= '0;
                  state   <= ARB_START;
               end
            end
            ARB_START: begin
               if (!m_ready) begin
                  m_start <= 1'b0;
                  state   <= ARB_BUSY;
               end else if (tmo == TMO_LAST) begin
                  err     <= grant;
                  m_start <= 1'b0;
                  grant   <= '0;
                  rr_ptr  <= next_ptr(owner);
                  gap_cnt <= '0;
                  state   <= ARB_GAP;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
            ARB_BUSY: begin
               if (m_ready) begin
                  done    <= grant;
                  grant   <= '0;
                  rr_ptr  <= next_ptr(owner);
                  gap_cnt <= '0;
                  state   <= ARB_GAP;
               end
            end
            ARB_GAP: begin
               if (gap_cnt == GAP_LAST) state <= ARB_IDLE;
               else                     gap_cnt <= gap_cnt + 8'd1;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Owner's transaction fields reach the master; all zero when nobody holds the grant
   always_comb begin
      m_addr    = '0;
      m_rw      = 1'b0;
      m_packets = '0;
      m_data    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            m_addr    = m_addr    | req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
            m_rw      = m_rw      | req_rw[i];
            m_packets = m_packets | req_packets[i*I2C_PKT_W +: I2C_PKT_W];
            m_data    = m_data    | req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
         end
      end
   end

   assign data_req   = grant & {NUM_REQ{m_data_req}};
   assign data_ready = grant & {NUM_REQ{m_data_ready}};
   assign rdata      = m_data_out;

endmodule
